collision_probe_arbiter: RTL and testbench

COLLISION_PROBE_ARBITER -- requirements
Module: collision_probe_arbiter

---
 rtl/collision_probe_pkg.sv | 42 ++++
 rtl/probe_addr_gen.sv | 77 +++++++
 rtl/collision_probe_arbiter.sv | 229 ++++++++++++++++++++++
 tb/tb_collision_probe_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/collision_probe_pkg.sv
// ---------------------------------------------------------------------------
// collision_probe_pkg
// Shared definitions for the sprite collision probe arbiter: screen geometry,
// the wall color the background lookup reports, the probe edge encoding, the
// scan FSM state encoding and the read-tag record carried alongside reads.
// Edge encoding doubles as the bit position inside one player's coll nibble
// ({L,R,D,U} -> bits 3..0).
// ---------------------------------------------------------------------------
package collision_probe_pkg;

   localparam int          SCREEN_W   = 640;
   localparam int          SCREEN_H   = 480;
   localparam int          ADDR_W     = 19;
   localparam logic [23:0] WALL_COLOR = 24'hFF5757;

   typedef enum logic [1:0] {
      EDGE_UP    = 2'd0,
      EDGE_DOWN  = 2'd1,
      EDGE_RIGHT = 2'd2,
      EDGE_LEFT  = 2'd3
   } probeEdgeT;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ARB    = 3'd1,
      ST_ISSUE  = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_COMMIT = 3'd4
   } scanStateT;

   typedef struct packed {
      logic      vld;
      logic      player;
      probeEdgeT side;
   } probeTagT;

   // Position of a (player, edge) flag inside the 8-bit coll vector.
   function automatic logic [2:0] flagIndex(input logic player, input probeEdgeT side);
      return {player, side};
   endfunction

endpackage

// File: rtl/probe_addr_gen.sv
// ---------------------------------------------------------------------------
// probe_addr_gen
// Combinational probe-point generator. For one sprite edge and a step index it
// produces the linear background address y*640+x of the probe point, whether
// the edge's fixed coordinate lies off-screen, and the last valid step index
// for that edge.
//
// Ports
//   spriteX   in  10  sprite left coordinate
//   spriteY   in  9   sprite top coordinate
//   side      in  2   edge being probed (probeEdgeT)
//   step      in  STEP_W  probe index along the edge, 0-based
//   addr      out 19  linear pixel address
//   offScreen out 1   fixed coordinate of the edge is outside the screen
//   lastStep  out STEP_W  final step index for this edge
// ---------------------------------------------------------------------------
module probe_addr_gen
   import collision_probe_pkg::*;
#(
   parameter int SPRITE_W = 24,
   parameter int SPRITE_H = 24,
   parameter int STEP_W   = 5
) (
   input  logic [9:0]        spriteX,
   input  logic [8:0]        spriteY,
   input  probeEdgeT         side,
   input  logic [STEP_W-1:0] step,
   output logic [18:0]       addr,
   output logic              offScreen,
   output logic [STEP_W-1:0] lastStep
);

   localparam logic [10:0]       RIGHT_OFS  = 11'(SPRITE_W + 1);
   localparam logic [9:0]        DOWN_OFS   = 10'(SPRITE_H + 1);
   localparam logic [STEP_W-1:0] LAST_HORIZ = STEP_W'(SPRITE_W - 2);
   localparam logic [STEP_W-1:0] LAST_VERT  = STEP_W'(SPRITE_H - 2);

   // One extra bit on each axis so RIGHT/DOWN probes past the screen edge
   // are seen as off-screen instead of wrapping.
   logic [10:0] probeX;
   logic [9:0]  probeY;

   always_comb begin
      probeX    = {1'b0, spriteX};
      probeY    = {1'b0, spriteY};
      offScreen = 1'b0;
      lastStep  = LAST_HORIZ;
      case (side)
         EDGE_UP: begin
            probeX    = {1'b0, spriteX} + 11'd1 + 11'(step);
            probeY    = {1'b0, spriteY} - 10'd1;
            offScreen = (spriteY == 9'd0);
         end
         EDGE_DOWN: begin
            probeX    = {1'b0, spriteX} + 11'd1 + 11'(step);
            probeY    = {1'b0, spriteY} + DOWN_OFS;
            offScreen = (probeY >= 10'(SCREEN_H));
         end
         EDGE_RIGHT: begin
            probeX    = {1'b0, spriteX} + RIGHT_OFS;
            probeY    = {1'b0, spriteY} + 10'd1 + 10'(step);
            offScreen = (probeX >= 11'(SCREEN_W));
            lastStep  = LAST_VERT;
         end
         default: begin
            probeX    = {1'b0, spriteX} - 11'd1;
            probeY    = {1'b0, spriteY} + 10'd1 + 10'(step);
            offScreen = (spriteX == 10'd0);
            lastStep  = LAST_VERT;
         end
      endcase
   end

   // Full-width multiply; the largest reachable address fits in 19 bits.
   assign addr = 19'(probeY) * 19'(SCREEN_W) + 19'(probeX);

endmodule

// File: rtl/collision_probe_arbiter.sv
// ---------------------------------------------------------------------------
// collision_probe_arbiter
// Once per frame_start, probes the background around two player sprites and
// reports which sprite edges touch a wall pixel. Edge jobs are granted in the
// order P0-UP, P1-UP, P0-DOWN, P1-DOWN, ... P1-LEFT; each in-screen job issues
// one read per probe point to a shared color lookup, waits out the read
// latency, then the arbiter moves on. Off-screen edges count as collided
// without any read. Results land in coll together with a one-cycle done.
//
// Ports
//   vga_clk      in   1   clock (rising edge)
//   reset        in   1   asynchronous active-high reset
//   frame_start  in   1   scan request pulse, accepted only when idle
//   player_en    in   2   per-player enable, bit0 = player 0
//   p0_x, p1_x   in   10  sprite left coordinates
//   p0_y, p1_y   in   9   sprite top coordinates
//   mem_rd       out  1   read strobe to the background lookup
//   mem_addr     out  19  linear pixel address of the read
//   mem_rdata    in   24  color, RD_LATENCY cycles after mem_rd
//   coll         out  8   {p1 L,R,D,U, p0 L,R,D,U}
//   done         out  1   scan-complete pulse, aligned with coll update
//   busy         out  1   scan in progress
//   overrun      out  1   sticky: frame_start seen while busy
//
// Build option: define COLLISION_OVERRUN_EN to implement the overrun flag;
// otherwise overrun is constant 0.
// ---------------------------------------------------------------------------
module collision_probe_arbiter
   import collision_probe_pkg::*;
#(
   parameter int SPRITE_W   = 24,
   parameter int SPRITE_H   = 24,
   parameter int RD_LATENCY = 2
) (
   input  logic        vga_clk,
   input  logic        reset,
   input  logic        frame_start,
   input  logic [1:0]  player_en,
   input  logic [9:0]  p0_x,
   input  logic [9:0]  p1_x,
   input  logic [8:0]  p0_y,
   input  logic [8:0]  p1_y,
   output logic        mem_rd,
   output logic [18:0] mem_addr,
   input  logic [23:0] mem_rdata,
   output logic [7:0]  coll,
   output logic        done,
   output logic        busy,
   output logic        overrun
);

   localparam int SPRITE_MAX = (SPRITE_W > SPRITE_H) ? SPRITE_W : SPRITE_H;
   localparam int STEP_W     = $clog2(SPRITE_MAX);
   localparam int DRAIN_W    = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
   localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(RD_LATENCY - 1);

   scanStateT         state, stateNext;
   logic [3:0]        jobIdx;
   logic [2:0]        curIdx;
   logic [STEP_W-1:0] stepCnt;
   logic [DRAIN_W-1:0] drainCnt;
   logic [7:0]        flags, flagsNext;

   // Frame snapshot, only meaningful while a scan runs.
   logic [1:0]        enSnap;
   logic [9:0]        x0Snap, x1Snap;
   logic [8:0]        y0Snap, y1Snap;

   logic              grantFound;
   logic [2:0]        grantIdx;
   logic [2:0]        selIdx;
   logic              selPlayer;
   probeEdgeT         selSide;
   logic [18:0]       genAddr;
   logic              genOff;
   logic [STEP_W-1:0] genLast;

   probeTagT          tagPipe [RD_LATENCY];
   logic [7:0]        matchMask;
   logic [7:0]        enMask;

   assign enMask = {{4{enSnap[1]}}, {4{enSnap[0]}}};

   always_ff @(posedge vga_clk) begin
      if (state == ST_IDLE && frame_start) begin
         enSnap <= player_en;
         x0Snap <= p0_x;
         y0Snap <= p0_y;
         x1Snap <= p1_x;
         y1Snap <= p1_y;
      end
   end

   // Lowest remaining job index whose player is enabled. Disabled players
   // are skipped here, so they never cost an ARB cycle.
   always_comb begin
      grantFound = 1'b0;
      grantIdx   = 3'd0;
      for (int j = 7; j >= 0; j--) begin
         if (4'(j) >= jobIdx && enSnap[1'(j)]) begin
            grantFound = 1'b1;
            grantIdx   = 3'(j);
         end
      end
   end

   // The address generator evaluates the candidate grant during ARB (for the
   // off-screen decision) and the committed job during ISSUE.
   assign selIdx    = (state == ST_ARB) ? grantIdx : curIdx;
   assign selPlayer = selIdx[0];
   assign selSide   = probeEdgeT'(selIdx[2:1]);

   probe_addr_gen #(
      .SPRITE_W (SPRITE_W),
      .SPRITE_H (SPRITE_H),
      .STEP_W   (STEP_W)
   ) uAddrGen (
      .spriteX   (selPlayer ? x1Snap : x0Snap),
      .spriteY   (selPlayer ? y1Snap : y0Snap),
      .side      (selSide),
      .step      (stepCnt),
      .addr      (genAddr),
      .offScreen (genOff),
      .lastStep  (genLast)
   );

   always_comb begin
      matchMask = 8'd0;
      if (tagPipe[RD_LATENCY-1].vld && mem_rdata == WALL_COLOR)
         matchMask[flagIndex(tagPipe[RD_LATENCY-1].player, tagPipe[RD_LATENCY-1].side)] = 1'b1;
   end

   always_comb begin
      stateNext = state;
      flagsNext = flags | matchMask;
      mem_rd    = 1'b0;
      mem_addr  = 19'd0;
      case (state)
         ST_IDLE: begin
            if (frame_start) begin
               stateNext = ST_ARB;
               flagsNext = 8'd0;
            end
         end
         ST_ARB: begin
            if (!grantFound)
               stateNext = ST_COMMIT;
            else if (genOff)
               flagsNext[flagIndex(grantIdx[0], probeEdgeT'(grantIdx[2:1]))] = 1'b1;
            else
               stateNext = ST_ISSUE;
         end
         ST_ISSUE: begin
            mem_rd   = 1'b1;
            mem_addr = genAddr;
            if (stepCnt == genLast)
               stateNext = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (drainCnt == DRAIN_LAST)
               stateNext = ST_ARB;
         end
         ST_COMMIT: stateNext = ST_IDLE;
         default:   stateNext = ST_IDLE;
      endcase
   end

   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         jobIdx   <= 4'd0;
         curIdx   <= 3'd0;
         stepCnt  <= '0;
         drainCnt <= '0;
         flags    <= 8'd0;
         coll     <= 8'd0;
         done     <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state <= stateNext;
         flags <= flagsNext;
         busy  <= (stateNext != ST_IDLE);
         done  <= (state == ST_ARB) && !grantFound;
         case (state)
            ST_IDLE: jobIdx <= 4'd0;
            ST_ARB: begin
               if (grantFound) begin
                  jobIdx  <= {1'b0, grantIdx} + 4'd1;
                  curIdx  <= grantIdx;
                  stepCnt <= '0;
               end else begin
                  coll <= flags & enMask;
               end
            end
            ST_ISSUE: begin
               stepCnt  <= stepCnt + STEP_W'(1);
               drainCnt <= '0;
            end
            ST_DRAIN: drainCnt <= drainCnt + DRAIN_W'(1);
            default: ;
         endcase
      end
   end

   // Read tag pipeline: stage k holds the tag of the read issued k+1 cycles
   // ago, so the last stage lines up with mem_rdata.
   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < RD_LATENCY; k++)
            tagPipe[k] <= '0;
      end else begin
         tagPipe[0] <= '{vld: mem_rd, player: curIdx[0], side: probeEdgeT'(curIdx[2:1])};
         for (int k = 1; k < RD_LATENCY; k++)
            tagPipe[k] <= tagPipe[k-1];
      end
   end

`ifdef COLLISION_OVERRUN_EN
   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset)
         overrun <= 1'b0;
      else if (frame_start && state != ST_IDLE)
         overrun <= 1'b1;
   end
`else
   assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_collision_probe_arbiter.sv
module tb_collision_probe_arbiter;

   localparam int          LAT  = 2;
   localparam logic [23:0] WALL = 24'hFF5757;

   logic        vga_clk = 1'b0;
   logic        reset;
   logic        frame_start;
   logic [1:0]  player_en;
   logic [9:0]  p0_x, p1_x;
   logic [8:0]  p0_y, p1_y;
   logic        mem_rd;
   logic [18:0] mem_addr;
   logic [23:0] mem_rdata;
   logic [7:0]  coll;
   logic        done, busy, overrun;

   always #5 vga_clk = ~vga_clk;

   collision_probe_arbiter #(
      .SPRITE_W   (24),
      .SPRITE_H   (24),
      .RD_LATENCY (LAT)
   ) dut (
      .vga_clk     (vga_clk),
      .reset       (reset),
      .frame_start (frame_start),
      .player_en   (player_en),
      .p0_x        (p0_x),
      .p1_x        (p1_x),
      .p0_y        (p0_y),
      .p1_y        (p1_y),
      .mem_rd      (mem_rd),
      .mem_addr    (mem_addr),
      .mem_rdata   (mem_rdata),
      .coll        (coll),
      .done        (done),
      .busy        (busy),
      .overrun     (overrun)
   );

   // Background lookup: one wall pixel (or none); non-read cycles return the
   // wall color so that stale data without a valid tag would be noticed.
   int          wallAddr = -1;
   logic [23:0] rdPipe [LAT];
   always @(posedge vga_clk) begin
      if (mem_rd)
         rdPipe[0] <= (int'(mem_addr) == wallAddr) ? WALL : {5'd0, mem_addr};
      else
         rdPipe[0] <= WALL;
      for (int k = 1; k < LAT; k++)
         rdPipe[k] <= rdPipe[k-1];
   end
   assign mem_rdata = rdPipe[LAT-1];

   int cycleCnt = 0;
   always @(posedge vga_clk) cycleCnt <= cycleCnt + 1;

   int         total = 0;
   int         bad   = 0;
   int         addrQ[$];
   logic [7:0] collQ[$];
   int         latQ[$];
   int         startCycle = 0;
   int         rdCnt = 0;

   task automatic check(input string name, input longint act, input longint exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every read and every done is matched against the
   // next expected entry.
   initial begin
      forever begin
         @(negedge vga_clk);
         if (reset === 1'b0) begin
            if (mem_rd) begin
               rdCnt++;
               total++;
               if (addrQ.size() == 0) begin
                  bad++;
                  $display("FAIL rd_addr: got unexpected read at %0d want no read", mem_addr);
               end else begin
                  int e;
                  e = addrQ.pop_front();
                  if (int'(mem_addr) != e) begin
                     bad++;
                     $display("FAIL rd_addr: got %0d want %0d", mem_addr, e);
                  end
               end
            end
            if (done) begin
               total++;
               if (collQ.size() == 0) begin
                  bad++;
                  $display("FAIL done_pulse: got unexpected done coll=%0h want none", coll);
               end else begin
                  logic [7:0] ec;
                  ec = collQ.pop_front();
                  if (coll !== ec) begin
                     bad++;
                     $display("FAIL coll: got %0h want %0h", coll, ec);
                  end
                  check("done_latency", cycleCnt - startCycle, latQ.pop_front());
               end
            end
         end
      end
   end

   // Reference probe order and addresses, straight from the edge geometry.
   task automatic modelScan(input int x0, y0, x1, y1, input logic [1:0] en, output int n);
      n = 0;
      for (int e = 0; e < 4; e++) begin
         for (int p = 0; p < 2; p++) begin
            int x, y;
            x = (p == 1) ? x1 : x0;
            y = (p == 1) ? y1 : y0;
            if (en[p]) begin
               for (int s = 0; s < 23; s++) begin
                  case (e)
                     0: if (y != 0)        begin addrQ.push_back((y - 1) * 640 + x + 1 + s);  n++; end
                     1: if (y + 25 < 480)  begin addrQ.push_back((y + 25) * 640 + x + 1 + s); n++; end
                     2: if (x + 25 < 640)  begin addrQ.push_back((y + 1 + s) * 640 + x + 25); n++; end
                     default: if (x != 0)  begin addrQ.push_back((y + 1 + s) * 640 + x - 1);  n++; end
                  endcase
               end
            end
         end
      end
   endtask

   task automatic runScan(input string tag, input int x0, y0, x1, y1, input logic [1:0] en,
                          input int wx, wy, input logic [7:0] expColl, input int expLat,
                          input int extraAt, input int resetAt);
      int  nRd;
      bit  gotDone, aborted;
      wallAddr = (wx < 0) ? -1 : wy * 640 + wx;
      modelScan(x0, y0, x1, y1, en, nRd);
      collQ.push_back(expColl);
      latQ.push_back(expLat);
      rdCnt = 0;
      p0_x = 10'(x0); p0_y = 9'(y0);
      p1_x = 10'(x1); p1_y = 9'(y1);
      player_en  = en;
      startCycle = cycleCnt + 1;
      frame_start = 1'b1;
      @(posedge vga_clk);
      #1;
      frame_start = 1'b0;
      // Inputs move after the start pulse; the scan must not follow them.
      p0_x = 10'($urandom); p0_y = 9'($urandom);
      p1_x = 10'($urandom); p1_y = 9'($urandom);
      player_en = 2'($urandom);
      gotDone = 0;
      aborted = 0;
      for (int c = 1; c <= 600 && !gotDone && !aborted; c++) begin
         @(negedge vga_clk);
         if (c == 1) check({tag, "_busy_start"}, busy, 1);
         if (done) begin
            gotDone = 1;
            check({tag, "_busy_commit"}, busy, 1);
         end
         frame_start = (c == extraAt);
         if (resetAt > 0 && c == resetAt) reset = 1'b1;
         if (resetAt > 0 && c == resetAt + 1) begin
            check({tag, "_rst_coll"}, coll, 0);
            check({tag, "_rst_busy"}, busy, 0);
            check({tag, "_rst_mem_rd"}, mem_rd, 0);
            check({tag, "_rst_mem_addr"}, mem_addr, 0);
            addrQ.delete();
            collQ.delete();
            latQ.delete();
            reset   = 1'b0;
            aborted = 1;
         end
      end
      @(negedge vga_clk);
      frame_start = 1'b0;
      if (!aborted) begin
         check({tag, "_done_seen"}, gotDone, 1);
         check({tag, "_done_one_cycle"}, done, 0);
         check({tag, "_rd_count"}, rdCnt, nRd);
         check({tag, "_rd_missing"}, addrQ.size(), 0);
      end
      repeat (3) @(negedge vga_clk);
      check({tag, "_busy_idle"}, busy, 0);
   endtask

   initial begin
      reset       = 1'b1;
      frame_start = 1'b0;
      player_en   = 2'b00;
      p0_x = '0; p0_y = '0; p1_x = '0; p1_y = '0;
      repeat (3) @(negedge vga_clk);
      check("reset_coll", coll, 0);
      check("reset_done", done, 0);
      check("reset_busy", busy, 0);
      check("reset_mem_rd", mem_rd, 0);
      check("reset_mem_addr", mem_addr, 0);
      check("reset_overrun", overrun, 0);
      reset = 1'b0;
      repeat (2) @(negedge vga_clk);

      // wall just above player 0's top edge
      runScan("wall_p0_up", 100, 100, 300, 200, 2'b11, 110, 99, 8'h01, 209, 0, 0);
      // player 0 in the corner: UP and LEFT off-screen, player 1 disabled
      runScan("corner_p0", 0, 0, 5, 5, 2'b01, -1, 0, 8'h09, 55, 0, 0);
      // no walls anywhere
      runScan("no_wall", 50, 60, 400, 300, 2'b11, -1, 0, 8'h00, 209, 0, 0);
      // player 1 near the bottom-right corner with a wall on its left side
      runScan("br_p1", 0, 0, 620, 460, 2'b10, 619, 470, 8'hE0, 55, 0, 0);
      // no players enabled
      runScan("none_en", 10, 10, 20, 20, 2'b00, -1, 0, 8'h00, 1, 0, 0);
      check("overrun_clear", overrun, 0);

      // second frame_start in the middle of a scan
      runScan("restart_mid", 100, 100, 300, 200, 2'b11, 110, 99, 8'h01, 209, 50, 0);
`ifdef COLLISION_OVERRUN_EN
      check("overrun_sticky", overrun, 1);
`else
      check("overrun_tied", overrun, 0);
`endif

      // reset in the middle of a scan, then a normal scan
      runScan("reset_mid", 50, 60, 400, 300, 2'b11, -1, 0, 8'h00, 209, 0, 100);
      check("overrun_after_reset", overrun, 0);
      runScan("after_reset", 100, 100, 300, 200, 2'b11, 110, 99, 8'h01, 209, 0, 0);

      // frame_start landing on the COMMIT cycle is dropped
      runScan("start_at_commit", 10, 10, 20, 20, 2'b00, -1, 0, 8'h00, 1, 2, 0);
      check("start_at_commit_q", collQ.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
